// File: rtl/step_seq_fsm.sv
// step_seq_fsm
//   Cyclic state sequencer. A 32-bit prescaler counts enabled clock cycles.
//   Every DIV_COUNT enabled cycles the state index takes one step, in a
//   direction chosen by mode. A single seven-segment digit shows the state.
//
// Ports
//   clk        in   1  system clock, all logic on posedge
//   reset      in   1  synchronous, active-high; overrides load and en
//   en         in   1  1: prescaler advances; 0: prescaler and state frozen
//   mode       in   2  00 up, 01 down, 10 skip (+STRIDE), 11 hold
//   load       in   1  one-cycle preload request
//   load_val   in   4  preload value
//   state_idx  out  4  current state (registered)
//   seg        out  7  active-low {a,b,c,d,e,f,g}, decoded from state_idx
//   tick       out  1  one-cycle pulse in the cycle after each step edge
//   wrap       out  1  one-cycle pulse with tick when that step wrapped
//   err        out  1  one-cycle pulse after a load with load_val >= NUM_STATES
//
// Load handshake: load has no ready/ack. Any cycle with load=1 is one
// request, consumed at that posedge. A valid request always wins over a
// step on the same edge. An out-of-range request only raises err.
module step_seq_fsm #(
    parameter int NUM_STATES = 6,
    parameter int STRIDE     = 2,
    parameter int DIV_COUNT  = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] state_idx,
    output logic [6:0] seg,
    output logic       tick,
    output logic       wrap,
    output logic       err
);

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_SKIP = 2'b10,
        MODE_HOLD = 2'b11
    } mode_t;

    localparam logic [31:0] DIV_LAST = 32'(DIV_COUNT - 1);
    localparam logic [4:0]  N5       = 5'(NUM_STATES);
    localparam logic [4:0]  STRIDE5  = 5'(STRIDE);
    localparam logic [3:0]  LAST_ST  = 4'(NUM_STATES - 1);

    logic [31:0] cnt, cnt_next;
    logic [3:0]  state_next;
    logic        step, load_ok, step_wrap;
    logic        tick_next, wrap_next, err_next;
    logic [4:0]  skip_sum;
    mode_t       mode_e;

    assign mode_e   = mode_t'(mode);
    assign step     = en && (cnt == DIV_LAST);
    assign load_ok  = load && ({1'b0, load_val} < N5);
    // Computed one bit wider so that s+STRIDE cannot overflow before the compare.
    assign skip_sum = {1'b0, state_idx} + STRIDE5;

    always_comb begin
        state_next = state_idx;
        cnt_next   = cnt;
        step_wrap  = 1'b0;
        tick_next  = 1'b0;
        wrap_next  = 1'b0;
        err_next   = 1'b0;

        if (en) begin
            cnt_next = (cnt == DIV_LAST) ? 32'd0 : cnt + 32'd1;
        end

        unique case (mode_e)
            MODE_UP: begin
                step_wrap = (state_idx == LAST_ST);
            end
            MODE_DOWN: begin
                step_wrap = (state_idx == 4'd0);
            end
            MODE_SKIP: begin
                step_wrap = (skip_sum >= N5);
            end
            MODE_HOLD: begin
                step_wrap = 1'b0;
            end
        endcase

        if (step) begin
            unique case (mode_e)
                MODE_UP:   state_next = step_wrap ? 4'd0 : state_idx + 4'd1;
                MODE_DOWN: state_next = step_wrap ? LAST_ST : state_idx - 4'd1;
                MODE_SKIP: state_next = step_wrap ? 4'(skip_sum - N5) : skip_sum[3:0];
                MODE_HOLD: state_next = state_idx;
            endcase
            tick_next = 1'b1;
            wrap_next = step_wrap;
        end

        // A valid preload restarts the interval and cancels any coincident step.
        if (load_ok) begin
            state_next = load_val;
            cnt_next   = 32'd0;
            tick_next  = 1'b0;
            wrap_next  = 1'b0;
        end

        err_next = load && !load_ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= 32'd0;
            state_idx <= 4'd0;
            tick      <= 1'b0;
            wrap      <= 1'b0;
            err       <= 1'b0;
        end else begin
            cnt       <= cnt_next;
            state_idx <= state_next;
            tick      <= tick_next;
            wrap      <= wrap_next;
            err       <= err_next;
        end
    end

    always_comb begin
        seg = 7'b1111111;
        unique case (state_idx)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
        endcase
    end

endmodule

// File: tb/tb_step_seq_fsm.sv
module tb_step_seq_fsm;

    logic       clk;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] state_idx;
    logic [6:0] seg;
    logic       tick;
    logic       wrap;
    logic       err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] exp_q[$];

    step_seq_fsm #(
        .NUM_STATES(6),
        .STRIDE    (2),
        .DIV_COUNT (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .state_idx(state_idx),
        .seg      (seg),
        .tick     (tick),
        .wrap     (wrap),
        .err      (err)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance n posedges; outputs are stable 1 time unit after the edge.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic [1:0] m);
        reset = 1'b1;
        load  = 1'b0;
        mode  = m;
        cyc(1);
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        mode     = 2'b00;
        load     = 1'b0;
        load_val = 4'd0;
        cyc(2);
        check("rst_state", 32'(state_idx), 32'd0);
        check("rst_seg", 32'(seg), 32'b0000001);
        check("rst_pulses", {29'd0, tick, wrap, err}, 32'd0);

        // 1. up mode, 24 edges
        reset = 1'b0;
        en    = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            cyc(1);
            if (i % 4 == 0) begin
                check("up_state", 32'(state_idx), 32'((i / 4) % 6));
                check("up_tick", 32'(tick), 32'd1);
                check("up_wrap", 32'(wrap), (i == 24) ? 32'd1 : 32'd0);
            end else begin
                check("up_notick", 32'(tick), 32'd0);
            end
            if (i == 4) check("up_seg1", 32'(seg), 32'b1001111);
        end

        // 2. down mode
        do_reset(2'b01);
        cyc(4);
        check("dn_state5", 32'(state_idx), 32'd5);
        check("dn_wrap5", 32'(wrap), 32'd1);
        check("dn_seg5", 32'(seg), 32'b0100100);
        cyc(4);
        check("dn_state4", 32'(state_idx), 32'd4);
        check("dn_wrap4", 32'(wrap), 32'd0);
        check("dn_tick4", 32'(tick), 32'd1);

        // 3. skip mode: expected sequence 2,4,0,2
        do_reset(2'b10);
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd4);
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd2);
        for (int k = 0; k < 4; k++) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            cyc(4);
            check("skip_state", 32'(state_idx), 32'(e));
            check("skip_wrap", 32'(wrap), (k == 2) ? 32'd1 : 32'd0);
        end

        // 4. hold mode for 12 cycles at state 2
        begin
            int ticks, wraps;
            ticks = 0;
            wraps = 0;
            mode  = 2'b11;
            for (int i = 0; i < 12; i++) begin
                cyc(1);
                ticks += int'(tick);
                wraps += int'(wrap);
                check("hold_state", 32'(state_idx), 32'd2);
            end
            check("hold_ticks", 32'(ticks), 32'd3);
            check("hold_wraps", 32'(wraps), 32'd0);
        end
        // prescaler freeze: 2 enabled edges, 6 disabled, then step on the 2nd re-enabled edge
        cyc(2);
        en = 1'b0;
        begin
            int ticks;
            ticks = 0;
            for (int i = 0; i < 6; i++) begin
                cyc(1);
                ticks += int'(tick);
            end
            check("en0_ticks", 32'(ticks), 32'd0);
        end
        en = 1'b1;
        cyc(1);
        check("en1_notick", 32'(tick), 32'd0);
        cyc(1);
        check("en1_tick", 32'(tick), 32'd1);

        // 5. load behaviour
        do_reset(2'b00);
        cyc(2);                          // cnt = 2
        load     = 1'b1;
        load_val = 4'd3;
        cyc(1);
        load = 1'b0;
        check("ld_state", 32'(state_idx), 32'd3);
        check("ld_notick", 32'(tick), 32'd0);
        cyc(3);
        check("ld_wait_state", 32'(state_idx), 32'd3);
        check("ld_wait_tick", 32'(tick), 32'd0);
        cyc(1);
        check("ld_step_state", 32'(state_idx), 32'd4);
        check("ld_step_tick", 32'(tick), 32'd1);
        // out-of-range load, no coincident step (cnt = 0)
        load     = 1'b1;
        load_val = 4'd9;
        cyc(1);
        load = 1'b0;
        check("err_pulse", 32'(err), 32'd1);
        check("err_state", 32'(state_idx), 32'd4);
        cyc(1);
        check("err_clear", 32'(err), 32'd0);
        cyc(1);                          // cnt = 3
        // out-of-range load coincident with a step: step proceeds
        load     = 1'b1;
        load_val = 4'd9;
        cyc(1);
        load = 1'b0;
        check("err_step_err", 32'(err), 32'd1);
        check("err_step_tick", 32'(tick), 32'd1);
        check("err_step_state", 32'(state_idx), 32'd5);
        // valid load on a step edge at state 5: no tick, no wrap
        cyc(3);                          // cnt = 3
        load     = 1'b1;
        load_val = 4'd1;
        cyc(1);
        load = 1'b0;
        check("ldstep_state", 32'(state_idx), 32'd1);
        check("ldstep_tick", 32'(tick), 32'd0);
        check("ldstep_wrap", 32'(wrap), 32'd0);
        // load honoured while disabled
        en       = 1'b0;
        load     = 1'b1;
        load_val = 4'd2;
        cyc(1);
        load = 1'b0;
        check("ld_en0_state", 32'(state_idx), 32'd2);
        check("ld_en0_seg", 32'(seg), 32'b0010010);
        en = 1'b1;

        // 6. reset mid-interval at state 4, overriding a valid load
        do_reset(2'b00);
        cyc(16);
        check("pre_rst_state", 32'(state_idx), 32'd4);
        check("pre_rst_tick", 32'(tick), 32'd1);
        cyc(2);
        reset    = 1'b1;
        load     = 1'b1;
        load_val = 4'd3;
        cyc(1);
        reset = 1'b0;
        load  = 1'b0;
        check("mid_rst_state", 32'(state_idx), 32'd0);
        check("mid_rst_seg", 32'(seg), 32'b0000001);
        check("mid_rst_pulses", {29'd0, tick, wrap, err}, 32'd0);
        cyc(3);
        check("post_rst_notick", 32'(tick), 32'd0);
        cyc(1);
        check("post_rst_state", 32'(state_idx), 32'd1);
        check("post_rst_tick", 32'(tick), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
